// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: FSM states, ALU select encoding,
// grant-counter width and the saturating counter helper.
package alu_arb_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) begin
            sat_inc = cnt;
        end else begin
            sat_inc = cnt + CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin search: first requester after last_grant,
// wrapping modulo NUM_REQ.
module rr_picker
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    localparam int CW = IDX_W + 1;

    logic [CW-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant  = '0;
        cand_s = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand_s = {1'b0, last_grant} + CW'(off);
            if (cand_s >= CW'(NUM_REQ)) begin
                cand_s = cand_s - CW'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (req[cand_s[IDX_W-1:0]]) begin
                grant = cand_s[IDX_W-1:0];
            end else begin
                grant = grant;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among NUM_REQ
// requesters. Optional per-requester grant counters: define ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_op1,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_op2,
    input  logic [NUM_REQ-1:0][1:0]        req_sel,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [DATA_W-1:0]              resp_data,
    output logic [DATA_W-1:0]              alu_op1,
    output logic [DATA_W-1:0]              alu_op2,
    output logic [1:0]                     alu_sel,
    input  logic [DATA_W-1:0]              alu_res,
    output logic [NUM_REQ-1:0][CNT_W-1:0]  grant_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e        state_r;
    arb_state_e        state_s;
    logic [IDX_W-1:0]  last_grant_r;
    logic [IDX_W-1:0]  grant_r;
    logic [IDX_W-1:0]  pick_s;
    logic              any_req_s;
    logic              accept_s;
    logic              resp_hs_s;
    logic [DATA_W-1:0] op1_r;
    logic [DATA_W-1:0] op2_r;
    alu_sel_e          sel_r;
    logic [DATA_W-1:0] result_r;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (pick_s),
        .any_req    (any_req_s)
    );

    // Only the granted requester's resp_ready can close the response.
    assign accept_s  = (state_r == IDLE) && any_req_s;
    assign resp_hs_s = (state_r == RESP) && resp_ready[grant_r];

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = RESP;
            RESP: begin
                if (resp_hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake strobes decoded from the current state and grant.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (accept_s) begin
            req_ready[pick_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        if (state_r == RESP) begin
            resp_valid[grant_r] = 1'b1;
        end else begin
            resp_valid = '0;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, result capture and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            grant_r      <= '0;
            op1_r        <= '0;
            op2_r        <= '0;
            sel_r        <= ALU_ADD;
            result_r     <= '0;
        end else begin
            if (accept_s) begin
                grant_r <= pick_s;
                op1_r   <= req_op1[pick_s];
                op2_r   <= req_op2[pick_s];
                sel_r   <= alu_sel_e'(req_sel[pick_s]);
            end
            if (state_r == ISSUE) begin
                result_r <= alu_res;
            end
            if (resp_hs_s) begin
                last_grant_r <= grant_r;
            end
        end
    end

    assign alu_op1   = op1_r;
    assign alu_op2   = op2_r;
    assign alu_sel   = sel_r;
    assign resp_data = result_r;

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] count_r;

    // Saturating count of completed responses per requester.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (resp_hs_s) begin
            count_r[grant_r] <= sat_inc(count_r[grant_r]);
        end
    end

    assign grant_count = count_r;
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
`ifdef ALU_ARB_STATS_EN
    localparam int EXP_CNT = 10;
`else
    localparam int EXP_CNT = 0;
`endif

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [N-1:0]           req_valid = '0;
    logic [N-1:0]           req_ready;
    logic [N-1:0][DW-1:0]   req_op1 = '0;
    logic [N-1:0][DW-1:0]   req_op2 = '0;
    logic [N-1:0][1:0]      req_sel = '0;
    logic [N-1:0]           resp_valid;
    logic [N-1:0]           resp_ready = '0;
    logic [DW-1:0]          resp_data;
    logic [DW-1:0]          alu_op1;
    logic [DW-1:0]          alu_op2;
    logic [1:0]             alu_sel;
    logic [DW-1:0]          alu_res;
    logic [N-1:0][15:0]     grant_count;

    logic [N-1:0][DW-1:0]   nxt_op1 = '0;
    logic [N-1:0][DW-1:0]   nxt_op2 = '0;
    logic [N-1:0][1:0]      nxt_sel = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: transaction in flight, cycles since accept.
    bit            m_busy = 1'b0;
    int            m_cnt  = 0;
    int            m_g    = 0;
    int            m_last = N - 1;
    logic [DW-1:0] m_exp  = '0;

    typedef struct {
        int            idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    sel;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[7];
    int   gq[$];
    int   gc[$];
    int   exp_order[5] = '{0, 1, 2, 3, 0};

    alu_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_sel     (req_sel),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_sel     (alu_sel),
        .alu_res     (alu_res),
        .grant_count (grant_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [1:0] s);
        case (s)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_res = ref_alu(alu_op1, alu_op2, alu_sel);

    function automatic int rr_pick(input int last, input logic [N-1:0] mask);
        for (int i = 1; i <= N; i++) begin
            if (mask[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare the current cycle's outputs with the model, then advance it.
    task automatic model_check();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        exp_rdy = '0;
        exp_rv  = '0;
        if (!m_busy) begin
            if (req_valid != '0) begin
                m_g     = rr_pick(m_last, req_valid);
                exp_rdy = onehot(m_g);
                m_exp   = ref_alu(req_op1[m_g], req_op2[m_g], req_sel[m_g]);
                m_busy  = 1'b1;
                m_cnt   = 0;
            end
        end else if (m_cnt == 0) begin
            m_cnt = 1;
        end else begin
            exp_rv = onehot(m_g);
            check("resp_data", resp_data, m_exp);
            if (resp_ready[m_g]) begin
                m_busy = 1'b0;
                m_last = m_g;
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    endtask

    task automatic step(input logic [N-1:0] rv, input logic [N-1:0] rr);
        @(posedge clock);
        #1;
        req_valid  = rv;
        resp_ready = rr;
        req_op1    = nxt_op1;
        req_op2    = nxt_op2;
        req_sel    = nxt_sel;
        #1;
        model_check();
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #1;
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        @(posedge clock);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_alu_op1", alu_op1, 32'd0);
        check("rst_alu_op2", alu_op2, 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        for (int i = 0; i < N; i++) check("rst_grant_count", 32'(grant_count[i]), 32'd0);
        reset  = 1'b0;
        m_busy = 1'b0;
        m_cnt  = 0;
        m_last = N - 1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            nxt_op1[i] = $urandom();
            nxt_op2[i] = $urandom();
            nxt_sel[i] = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic single_op(input int idx);
        step(onehot(idx), '0);
        step('0, '0);
        step('0, onehot(idx));
    endtask

    initial begin
        vecs[0] = '{0, 32'd5,          32'd3,          2'b00, 32'd8};
        vecs[1] = '{1, 32'hFFFF_FFFF,  32'd1,          2'b00, 32'd0};
        vecs[2] = '{2, 32'd0,          32'd1,          2'b01, 32'hFFFF_FFFF};
        vecs[3] = '{3, 32'hF0F0_1234,  32'h0FF0_FFFF,  2'b10, 32'h00F0_1234};
        vecs[4] = '{0, 32'hA5A5_0000,  32'h0000_5A5A,  2'b11, 32'hA5A5_5A5A};
        vecs[5] = '{1, 32'h0000_0100,  32'd1,          2'b01, 32'h0000_00FF};
        vecs[6] = '{2, 32'h7FFF_FFFF,  32'd1,          2'b00, 32'h8000_0000};

        apply_reset();
        step('0, '0);

        // Directed vector table: one single-requester transaction per row.
        for (int v = 0; v < 7; v++) begin
            nxt_op1[vecs[v].idx] = vecs[v].a;
            nxt_op2[vecs[v].idx] = vecs[v].b;
            nxt_sel[vecs[v].idx] = vecs[v].sel;
            step(onehot(vecs[v].idx), '0);
            step('0, '0);
            step('0, onehot(vecs[v].idx));
            check("vec_result", resp_data, vecs[v].exp);
        end

        // Contention: everybody requesting, everybody ready.
        apply_reset();
        rand_ops();
        gq.delete();
        gc.delete();
        for (int s = 0; s < 15; s++) begin
            step('1, '1);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    gq.push_back(i);
                    gc.push_back(cyc);
                end
            end
        end
        check("cont_grants", 32'(gq.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) begin
                check("cont_order", 32'(gq[k]), 32'(exp_order[k]));
                if (k > 0) check("cont_interval", 32'(gc[k] - gc[k-1]), 32'd3);
            end
        end

        // Backpressure on requester 2; other requests and readies are ignored.
        apply_reset();
        rand_ops();
        step(4'b0100, '0);
        step('1, '0);
        for (int s = 0; s < 5; s++) begin
            rand_ops();
            step('1, 4'b1011);
        end
        step('1, 4'b0100);
        step('0, '0);
        step('0, '0);

        // Reset while a response is pending abandons it.
        apply_reset();
        rand_ops();
        single_op(2);
        step(4'b0010, '0);
        step('0, '0);
        step('0, '0);
        apply_reset();
        step('1, '0);
        check("post_reset_grant", 32'(req_ready), 32'h1);
        step('0, '0);
        step('0, 4'b0001);
        step('0, '0);

        // Grant counters: ten completed grants to requester 1.
        apply_reset();
        for (int t = 0; t < 10; t++) begin
            rand_ops();
            single_op(1);
        end
        step('0, '0);
        for (int i = 0; i < N; i++) begin
            check("grant_count", 32'(grant_count[i]), (i == 1) ? 32'(EXP_CNT) : 32'd0);
        end

        // Randomized traffic against the model.
        apply_reset();
        for (int s = 0; s < 400; s++) begin
            rand_ops();
            step(($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15)),
                 N'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one ALU (legal range 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the operand and result width.
REQ-003 The block SHALL have port clock, input, 1 bit, the clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits, a per-requester operation request.
REQ-006 The block SHALL have port req_ready, output, NUM_REQ bits, a per-requester accept strobe.
REQ-007 The block SHALL have ports req_op1 and req_op2, input, NUM_REQ x DATA_W, the per-requester operands.
REQ-008 The block SHALL have port req_sel, input, NUM_REQ x 2, the per-requester ALU select.
REQ-009 The block SHALL have port resp_valid, output, NUM_REQ bits, a per-requester result valid.
REQ-010 The block SHALL have port resp_ready, input, NUM_REQ bits, a per-requester result accept.
REQ-011 The block SHALL have port resp_data, output, DATA_W bits, the result of the granted operation.
REQ-012 The block SHALL have ports alu_op1 and alu_op2 (output, DATA_W), alu_sel (output, 2), and alu_res (input, DATA_W), forming the shared combinational ALU port.
REQ-013 The block SHALL have port grant_count, output, NUM_REQ x 16, the per-requester completed-grant counters.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-015 In IDLE with any req_valid set, the block SHALL pick grant g round-robin:
- search starts at last_grant+1 and wraps modulo NUM_REQ;
- req_ready[g] pulses high for that single cycle;
- req_op1[g], req_op2[g] and req_sel[g] are latched;
- next state is ISSUE.
REQ-016 In IDLE with no req_valid set, the block SHALL stay in IDLE with req_ready all zero.
REQ-017 alu_op1, alu_op2 and alu_sel SHALL always be driven from the latched registers.
REQ-018 In ISSUE, the block SHALL capture alu_res into the result register and move to RESP.
REQ-019 In RESP, resp_valid[g] SHALL be high, resp_data SHALL equal the result register, and all other resp_valid bits SHALL be low.
REQ-020 RESP SHALL hold until resp_ready[g]=1; on that edge last_grant<=g and the FSM returns to IDLE.
REQ-021 resp_ready bits of non-granted requesters SHALL be ignored.
REQ-022 Minimum request-to-response latency SHALL be 2 cycles (accept edge, then ISSUE edge).
REQ-023 Minimum issue interval SHALL be 3 cycles, with at most one operation in flight.
REQ-024 req_valid changes during ISSUE or RESP SHALL have no effect; req_ready SHALL stay zero outside IDLE.
REQ-025 Results SHALL wrap at DATA_W bits; the block performs no arithmetic itself.

Reset
REQ-026 While reset is high, the block SHALL set:
- state=IDLE, last_grant=NUM_REQ-1 (so requester 0 is first priority);
- latched operands=0, alu_sel=0, resp_data=0;
- req_ready=0, resp_valid=0, grant_count=0.
REQ-027 Reset asserted mid-operation (ISSUE or RESP) SHALL abandon the operation; no response is produced after release.

Configuration
REQ-028 With macro ALU_ARB_STATS_EN defined, grant_count[g] SHALL increment on each RESP handshake of g and saturate at 16'hFFFF.
REQ-029 Without ALU_ARB_STATS_EN, grant_count SHALL be tied to zero and no counter flops SHALL be generated.

Structure
REQ-030 Package alu_arb_pkg SHALL hold the FSM state enum, the 2-bit alu_sel typedef (00 add, 01 sub, 10 and, 11 or) and the counter width constant (16).
REQ-031 Sub-module rr_picker SHALL hold the combinational round-robin search, with inputs req mask and last_grant and outputs grant index and any_req.

Verification
REQ-032 Single request: reset, then req_valid=0001, op1=5, op2=3, sel=00, with an adder model on the ALU port -> req_ready[0] pulse, resp_valid[0] 2 cycles later, resp_data=8.
REQ-033 Contention: req_valid=1111 held, resp_ready=1111 -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-034 Backpressure: resp_ready[2]=0 for 5 cycles -> resp_valid[2] and resp_data stay stable, req_ready=0 throughout, then IDLE.
REQ-035 Wrap: op1=32'hFFFFFFFF, op2=1, sel=00 -> resp_data=0; sel=01 with op1=0, op2=1 -> 32'hFFFFFFFF.
REQ-036 Reset in RESP -> resp_valid=0 the next cycle, and the next grant goes to requester 0.
REQ-037 With ALU_ARB_STATS_EN, 10 grants to requester 1 -> grant_count[1]=10, others 0; without the macro, all counters stay 0.
